hevc_dct4_mac_seq: RTL and testbench
====================================

// Module: hevc_dct4_mac_seq
// PURPOSE
//  Sequencer for the HEVC 4x4 DCT coefficient ROM. Accepts one 4-sample row vector and
//  walks the ROM (row k, col n) with a single shared signed multiplier-accumulator.
//  Emits the 1-D forward transform Y[k] = sum_n C[k][n]*x[n], k=0..3, one coefficient per handshake.
//  Sits between the residual row buffer and the transpose/second-pass stage.
// PARAMETERS
//  DATA_W   16   signed input sample width
//  SHIFT    0    rounding right-shift applied to each Y[k]; 0 = no shift, no rounding
//  ACC_W    DATA_W+10  (localparam) accumulator/output width; 8b coeff + 2b for 4-term sum
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         input vector valid
//  in_ready   out  1         block can accept a vector
//  in_data    in   4*DATA_W  x[0] in [DATA_W-1:0] ... x[3] in MSBs, two's complement
//  rom_row    out  2         coefficient ROM row address (= k)
//  rom_col    out  2         coefficient ROM column address (= n)
//  rom_coeff  in   8         signed ROM data, combinational from rom_row/rom_col
//  out_valid  out  1         Y[out_idx] valid
//  out_ready  in   1         downstream accepts Y
//  out_data   out  ACC_W     signed Y[k] after optional rounding shift
//  out_idx    out  2         k of out_data
//  busy       out  1         high in any state other than IDLE
//  done       out  1         one-cycle pulse when Y[3] is accepted
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, k=n=0, acc=0, sample reg=0; outputs: in_ready=1 (IDLE),
//   out_valid=0, out_data=0, out_idx=0, rom_row=rom_col=0, busy=0, done=0. Any in-flight vector is dropped.
//  FSM states: IDLE, MAC, OUT.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch in_data, k=0, n=0, acc=0 -> MAC.
//   MAC: rom_row=k, rom_col=n; acc <= acc + rom_coeff*x[n] (signed, full ACC_W precision).
//        n increments each cycle; at n=3 the final sum is registered into out_data -> OUT. Takes 4 cycles.
//   OUT: out_valid=1, out_idx=k, out_data stable until accepted.
//        On out_valid&&out_ready: if k<3 then k++, n=0, acc=0 -> MAC; else done=1 -> IDLE.
//  in_ready=0 in MAC and OUT; in_valid ignored there, so no second vector overlaps.
//  Latency: accept at edge T -> MAC cycles T+1..T+4 -> out_valid high from T+5 (Y[0]).
//   Zero-stall throughput is one vector per 21 cycles (accept + 4x(4 MAC + 1 OUT)).
//  Backpressure: out_ready=0 holds OUT indefinitely; out_data/out_idx must not change while held.
//  Arithmetic: product is 8b x DATA_W signed; sum of 4 terms fits ACC_W with no overflow.
//   SHIFT>0: out_data = (acc + (1<<(SHIFT-1))) >>> SHIFT, arithmetic shift, sign-extended to ACC_W.
//   No saturation.
//  rom_row/rom_col hold their last values outside MAC. done is registered and high only in the IDLE cycle after the last handshake.
//  rst asserted in any state has priority over every handshake in the same cycle.
// TESTING
//  T1 SHIFT=0, x=[1,0,0,0] -> Y=[64,83,64,36], idx 0..3, first out_valid 5 cycles after accept, done after Y[3].
//  T2 SHIFT=0, x=[10,10,10,10] -> Y=[2560,0,0,0]; in_ready=0 for the whole transform.
//  T3 DATA_W=16, x=[-32768]x4 -> Y0=-8388608, Y1..Y3=0; x=[32767,-32768,32767,-32768] -> Y1=3/ sign checked against golden model.
//  T4 SHIFT=7, x=[1,0,0,0] -> Y=[1,1,1,0]; x=[-1,0,0,0] -> Y=[0,-1,0,0] (round-half-up then arithmetic shift).
//  T5 Random out_ready (30% duty) with 100 random vectors -> every Y matches the golden matrix product.
//   out_data/out_idx stable while out_ready=0; no vector accepted while busy.
//  T6 Assert rst in MAC (k=2,n=1) and in OUT with out_ready=0 -> next cycle IDLE, out_valid=0, in_ready=1.
//   The next vector transforms correctly.

Source files
------------

// File: rtl/hevc_dct4_mac_seq.sv
// HEVC 4x4 forward DCT row sequencer: walks the coefficient ROM with one shared
// signed multiplier-accumulator and emits Y[0..3], one per output handshake.
module hevc_dct4_mac_seq #(
  parameter int  DATA_W = 16,
  parameter int  SHIFT  = 0,
  localparam int ACC_W  = DATA_W + 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [1:0]            rom_row,
  output logic [1:0]            rom_col,
  input  logic [7:0]            rom_coeff,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [1:0]            out_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  // Half-LSB rounding constant; zero when no shift is requested.
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;

  state_t                   state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic [1:0]               n_q, n_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;
  logic signed [DATA_W-1:0] x_q [4];
  logic signed [DATA_W-1:0] x_d [4];
  logic                     done_q, done_d;

  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    rnd_sum;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    x_d        = x_q;
    done_d     = 1'b0;

    prod    = ACC_W'($signed(rom_coeff)) * ACC_W'(x_q[n_q]);
    sum     = acc_q + prod;
    rnd_sum = (ACC_W+1)'(sum) + RND;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 4; i++) x_d[i] = in_data[i*DATA_W +: DATA_W];
          k_d     = 2'd0;
          n_d     = 2'd0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        if (n_q == 2'd3) begin
          // n stays at 3 so the ROM address holds its last value while in OUT.
          out_data_d = ACC_W'(rnd_sum >>> SHIFT);
          state_d    = S_OUT;
        end else begin
          n_d = n_q + 2'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (k_q != 2'd3) begin
            k_d     = k_q + 2'd1;
            n_d     = 2'd0;
            acc_d   = '0;
            state_d = S_MAC;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= 2'd0;
      n_q        <= 2'd0;
      acc_q      <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      // NOTE: the small sample register is reset so a dropped vector leaves nothing behind.
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      x_q        <= x_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_idx   = k_q;
  assign rom_row   = k_q;
  assign rom_col   = n_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hevc_dct4_mac_seq.sv
// Bench for hevc_dct4_mac_seq: two instances (SHIFT=0 and SHIFT=7) run in lockstep
// on shared stimulus; directed table vectors, random backpressure and reset corners.
module tb_hevc_dct4_mac_seq;
  localparam int DW = 16;
  localparam int AW = DW + 10;

  typedef longint vec_t [4];
  typedef struct {
    vec_t x;
    vec_t y;
    vec_t y7;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic [4*DW-1:0] in_data;

  logic          in_ready_s0, out_valid_s0, busy_s0, done_s0;
  logic [1:0]    rom_row_s0, rom_col_s0, out_idx_s0;
  logic [7:0]    coeff_s0;
  logic [AW-1:0] out_data_s0;

  logic          in_ready_s7, out_valid_s7, busy_s7, done_s7;
  logic [1:0]    rom_row_s7, rom_col_s7, out_idx_s7;
  logic [7:0]    coeff_s7;
  logic [AW-1:0] out_data_s7;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic signed [7:0] rom(input logic [1:0] r, input logic [1:0] c);
    logic signed [7:0] m [4][4];
    m[0] = '{8'sd64, 8'sd64, 8'sd64, 8'sd64};
    m[1] = '{8'sd83, 8'sd36, -8'sd36, -8'sd83};
    m[2] = '{8'sd64, -8'sd64, -8'sd64, 8'sd64};
    m[3] = '{8'sd36, -8'sd83, 8'sd83, -8'sd36};
    return m[r][c];
  endfunction

  assign coeff_s0 = rom(rom_row_s0, rom_col_s0);
  assign coeff_s7 = rom(rom_row_s7, rom_col_s7);

  hevc_dct4_mac_seq #(.DATA_W(DW), .SHIFT(0)) dut_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s0), .in_data(in_data),
    .rom_row(rom_row_s0), .rom_col(rom_col_s0), .rom_coeff(coeff_s0),
    .out_valid(out_valid_s0), .out_ready(out_ready), .out_data(out_data_s0),
    .out_idx(out_idx_s0), .busy(busy_s0), .done(done_s0));

  hevc_dct4_mac_seq #(.DATA_W(DW), .SHIFT(7)) dut_s7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s7), .in_data(in_data),
    .rom_row(rom_row_s7), .rom_col(rom_col_s7), .rom_coeff(coeff_s7),
    .out_valid(out_valid_s7), .out_ready(out_ready), .out_data(out_data_s7),
    .out_idx(out_idx_s7), .busy(busy_s7), .done(done_s7));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check2(input string name, input logic signed [63:0] a0, input logic signed [63:0] a7,
                        input logic signed [63:0] exp);
    check({name, "_s0"}, a0, exp);
    check({name, "_s7"}, a7, exp);
  endtask

  function automatic longint y_gold(input vec_t x, input int k);
    longint s = 0;
    for (int n = 0; n < 4; n++) s += longint'(rom(2'(k), 2'(n))) * x[n];
    return s;
  endfunction

  function automatic longint round7(input longint y);
    return (y + 64) >>> 7;
  endfunction

  function automatic logic [4*DW-1:0] pack(input vec_t x);
    logic [4*DW-1:0] p;
    for (int i = 0; i < 4; i++) p[i*DW +: DW] = x[i][DW-1:0];
    return p;
  endfunction

  // Runs one vector through both instances with out_ready asserted duty% of the time.
  task automatic run_vec(input vec_t x, input vec_t ey, input vec_t ey7, input int duty);
    int cnt;
    logic got, held;
    logic [AW-1:0] h0, h7;
    logic [1:0] hi;
    @(negedge clk);
    check2("idle_ready", in_ready_s0, in_ready_s7, 1);
    in_data   = pack(x);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    cnt = 1;
    for (int k = 0; k < 4; k++) begin
      got  = 1'b0;
      held = 1'b0;
      for (int t = 0; t < 200; t++) begin
        check2("busy_in_ready", in_ready_s0, in_ready_s7, 0);
        if (out_valid_s0) begin
          if (k == 0 && !held) check("first_out_latency", cnt, 5);
          if (held) begin
            check2("hold_data", out_data_s0 ^ h0, out_data_s7 ^ h7, 0);
            check2("hold_idx", out_idx_s0, out_idx_s7, hi);
          end
          out_ready = ($urandom_range(0, 99) < duty);
          if (out_ready) begin
            check("out_valid_s7", out_valid_s7, 1);
            check2("out_idx", out_idx_s0, out_idx_s7, k);
            check("y_s0", $signed(out_data_s0), ey[k]);
            check("y_s7", $signed(out_data_s7), ey7[k]);
            got = 1'b1;
          end else begin
            held = 1'b1;
            h0 = out_data_s0;
            h7 = out_data_s7;
            hi = out_idx_s0;
          end
        end
        // Offer a spurious vector while busy; it must be ignored.
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        cnt++;
        if (got) break;
      end
      if (!got) check("out_timeout", 0, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check2("done_pulse", done_s0, done_s7, 1);
    check2("busy_after", busy_s0, busy_s7, 0);
    check2("out_valid_after", out_valid_s0, out_valid_s7, 0);
    @(negedge clk);
    check2("done_clear", done_s0, done_s7, 0);
  endtask

  task automatic accept(input vec_t x, input logic ready);
    @(negedge clk);
    in_data   = pack(x);
    in_valid  = 1'b1;
    out_ready = ready;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check2({name, "_out_valid"}, out_valid_s0, out_valid_s7, 0);
    check2({name, "_in_ready"}, in_ready_s0, in_ready_s7, 1);
    check2({name, "_busy"}, busy_s0, busy_s7, 0);
    check2({name, "_done"}, done_s0, done_s7, 0);
    check2({name, "_out_idx"}, out_idx_s0, out_idx_s7, 0);
    check2({name, "_out_data"}, out_data_s0, out_data_s7, 0);
    check2({name, "_rom_row"}, rom_row_s0, rom_row_s7, 0);
    check2({name, "_rom_col"}, rom_col_s0, rom_col_s7, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t tbl [5];
    vec_t x, ey, ey7;
    logic signed [DW-1:0] r;

    tbl[0].x = '{1, 0, 0, 0};
    tbl[0].y = '{64, 83, 64, 36};
    tbl[0].y7 = '{1, 1, 1, 0};
    tbl[1].x = '{10, 10, 10, 10};
    tbl[1].y = '{2560, 0, 0, 0};
    tbl[1].y7 = '{20, 0, 0, 0};
    tbl[2].x = '{-32768, -32768, -32768, -32768};
    tbl[2].y = '{-8388608, 0, 0, 0};
    tbl[2].y7 = '{-65536, 0, 0, 0};
    tbl[3].x = '{32767, -32768, 32767, -32768};
    tbl[3].y = '{-128, 3080145, 0, 7798665};
    tbl[3].y7 = '{-1, 24064, 0, 60927};
    tbl[4].x = '{-1, 0, 0, 0};
    tbl[4].y = '{-64, -83, -64, -36};
    tbl[4].y7 = '{0, -1, 0, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tbl[i].x, tbl[i].y, tbl[i].y7, 100);

    // Random vectors under 30% out_ready duty.
    for (int v = 0; v < 100; v++) begin
      for (int i = 0; i < 4; i++) begin
        r = DW'($urandom);
        x[i] = r;
      end
      for (int k = 0; k < 4; k++) begin
        ey[k]  = y_gold(x, k);
        ey7[k] = round7(ey[k]);
      end
      run_vec(x, ey, ey7, 30);
    end

    // Reset while in MAC at k=2, n=1.
    accept(tbl[3].x, 1'b1);
    repeat (11) @(negedge clk);
    check2("mac_rom_row", rom_row_s0, rom_row_s7, 2);
    check2("mac_rom_col", rom_col_s0, rom_col_s7, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check_idle("rst_in_mac");
    run_vec(tbl[0].x, tbl[0].y, tbl[0].y7, 100);

    // Reset in OUT held by backpressure, with a handshake offered in the same cycle.
    accept(tbl[2].x, 1'b0);
    repeat (6) @(negedge clk);
    check2("held_out_valid", out_valid_s0, out_valid_s7, 1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check_idle("rst_in_out");
    run_vec(tbl[3].x, tbl[3].y, tbl[3].y7, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
